// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seg_display_sched block:
//   - active-low 7-segment codes (bit6 = g .. bit0 = a)
//   - scheduler FSM state encoding
//   - bcd_to_seg: one BCD digit to its segment code (nibble > 9 gives OFF)
// Optional build macro used by the block: DISP_SIGNED_EN (two's complement
// input values, see seg_display_sched.sv).
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam logic [6:0] ZERO  = 7'b1000000;
    localparam logic [6:0] ONE   = 7'b1111001;
    localparam logic [6:0] TWO   = 7'b0100100;
    localparam logic [6:0] THREE = 7'b0110000;
    localparam logic [6:0] FOUR  = 7'b0011001;
    localparam logic [6:0] FIVE  = 7'b0010010;
    localparam logic [6:0] SIX   = 7'b0000010;
    localparam logic [6:0] SEVEN = 7'b1111000;
    localparam logic [6:0] EIGHT = 7'b0000000;
    localparam logic [6:0] NINE  = 7'b0010000;
    localparam logic [6:0] MINUS = 7'b0111111;
    localparam logic [6:0] OFF   = 7'b1111111;

    // Three BCD digits: hundreds, tens, ones.
    localparam int BCD_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WRITE = 2'd2
    } seg_state_e;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = ZERO;
            4'd1:    code = ONE;
            4'd2:    code = TWO;
            4'd3:    code = THREE;
            4'd4:    code = FOUR;
            4'd5:    code = FIVE;
            4'd6:    code = SIX;
            4'd7:    code = SEVEN;
            4'd8:    code = EIGHT;
            4'd9:    code = NINE;
            default: code = OFF;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg_display_sched_if.sv
// -----------------------------------------------------------------------------
// seg_display_sched_if
// Request bus for the two requesters (UART RX byte path, UART TX byte path).
//   rx_valid/rx_data/rx_ready : RX requester
//   tx_valid/tx_data/tx_ready : TX requester
// Modports: master (requesters side), slave (seg_display_sched side).
//
// Handshake: a value transfers on a rising clock edge where valid && ready.
// Ready is a combinational function of valid and scheduler state, so a
// requester may raise or drop valid at any time; dropping valid before a
// transfer simply withdraws the request. At most one ready is high at once.
// -----------------------------------------------------------------------------
interface seg_display_sched_if #(
    parameter int W = 8
);
    logic         rx_valid;
    logic [W-1:0] rx_data;
    logic         rx_ready;
    logic         tx_valid;
    logic [W-1:0] tx_data;
    logic         tx_ready;

    modport master (
        output rx_valid, rx_data, tx_valid, tx_data,
        input  rx_ready, tx_ready
    );

    modport slave (
        input  rx_valid, rx_data, tx_valid, tx_data,
        output rx_ready, tx_ready
    );
endinterface

// File: rtl/seg_bcd_shifter.sv
// -----------------------------------------------------------------------------
// seg_bcd_shifter
// Iterative shift-add-3 (double-dabble) binary to 3-digit BCD converter.
// Converts one bit per clock, MSB first, over W clocks after a load.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : capture bin_i, clear BCD, start a W-step conversion
//   bin_i      : W-bit unsigned value to convert
//   bcd_o      : {hundreds, tens, ones}; final once the count has run out
//   last_o     : finished flag, high during the cycle whose edge performs the
//                last shift (count == 1), so the caller can step on exactly
//                when the result becomes final
// -----------------------------------------------------------------------------
module seg_bcd_shifter
    import seg_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [W-1:0]     bin_i,
    output logic [BCD_W-1:0] bcd_o,
    output logic             last_o
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]     bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        // Pre-correct every digit that would exceed 9 after doubling.
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        if (load_i) begin
            bin_d = bin_i;
            bcd_d = '0;
            cnt_d = CW'(W);
        end else if (cnt_q != '0) begin
            // {bcd, bin} <<= 1; bits beyond three digits are dropped, values
            // that large are flagged as overflow by the caller.
            bcd_d = {bcd_adj[BCD_W-2:0], bin_q[W-1]};
            bin_d = {bin_q[W-2:0], 1'b0};
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

    assign bcd_o  = bcd_q;
    assign last_o = (cnt_q == CW'(1));

endmodule

// File: rtl/seg_display_sched.sv
// -----------------------------------------------------------------------------
// seg_display_sched
// Shares one sequential binary-to-7-segment engine between the UART RX and
// UART TX byte paths with round-robin arbitration. RX results go to bank
// rx_d2..rx_d0 (HEX2..HEX0), TX results to tx_d2..tx_d0 (HEX5..HEX3).
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   bus (slave modport)  : rx/tx valid, data, ready request handshakes
//   rx_d2, rx_d1, rx_d0  : RX bank, active-low segments, bit6 = g .. bit0 = a
//   tx_d2, tx_d1, tx_d0  : TX bank, same encoding
//   busy                 : engine not idle
//   done, done_src       : one-cycle pulse when a bank is written; 0=RX 1=TX
//   dbg_state_o          : scheduler FSM state
// Timing: handshake at edge k, bank written at edge k+W+1, next handshake
// possible at edge k+W+2.
// Build option: define DISP_SIGNED_EN to treat data as two's complement;
// negatives show a leading MINUS, magnitudes >= 100 show all MINUS.
// Without it data is unsigned and MINUS only appears on overflow (> 999).
// -----------------------------------------------------------------------------
module seg_display_sched
    import seg_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    seg_display_sched_if.slave  bus,
    output logic [6:0]          rx_d2,
    output logic [6:0]          rx_d1,
    output logic [6:0]          rx_d0,
    output logic [6:0]          tx_d2,
    output logic [6:0]          tx_d1,
    output logic [6:0]          tx_d0,
    output logic                busy,
    output logic                done,
    output logic                done_src,
    output seg_state_e          dbg_state_o
);

    localparam logic [20:0] BANK_RESET = {OFF, OFF, ZERO};

    seg_state_e   state_q;
    logic         last_tx_q;     // last served requester: 1 = TX, 0 = RX
    logic         src_q;         // requester being converted
    logic         ovf_q;
    logic         neg_q;
    logic [20:0]  rx_bank_q;     // {d2, d1, d0}
    logic [20:0]  tx_bank_q;
    logic         done_q;
    logic         done_src_q;

    logic         grant_rx;
    logic         grant_tx;
    logic [W-1:0] sel_data;
    logic [W-1:0] mag_d;
    logic         neg_d;
    logic         ovf_d;

    logic [BCD_W-1:0] bcd;
    logic             last_shift;
    logic [20:0]      bank_d;

    // Arbiter: only in IDLE; on contention the requester not served last wins.
    always_comb begin
        grant_rx = 1'b0;
        grant_tx = 1'b0;
        if (state_q == ST_IDLE) begin
            if (bus.rx_valid && (!bus.tx_valid || last_tx_q)) begin
                grant_rx = 1'b1;
            end else if (bus.tx_valid) begin
                grant_tx = 1'b1;
            end
        end
    end

    assign bus.rx_ready = grant_rx;
    assign bus.tx_ready = grant_tx;

    // Value presented to the engine and its range classification.
    always_comb begin
        sel_data = grant_tx ? bus.tx_data : bus.rx_data;
`ifdef DISP_SIGNED_EN
        neg_d = sel_data[W-1];
        mag_d = neg_d ? (~sel_data + W'(1)) : sel_data;
        ovf_d = neg_d ? (32'(mag_d) >= 32'd100) : (32'(mag_d) > 32'd999);
`else
        neg_d = 1'b0;
        mag_d = sel_data;
        ovf_d = (32'(sel_data) > 32'd999);
`endif
    end

    seg_bcd_shifter #(
        .W (W)
    ) u_shifter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (grant_rx | grant_tx),
        .bin_i  (mag_d),
        .bcd_o  (bcd),
        .last_o (last_shift)
    );

    // Bank image for the finished conversion, with leading-zero blanking.
    always_comb begin
        logic [3:0] hun, ten, one;
        hun = bcd[11:8];
        ten = bcd[7:4];
        one = bcd[3:0];
        bank_d = {OFF, OFF, bcd_to_seg(one)};
        if (ovf_q) begin
            bank_d = {MINUS, MINUS, MINUS};
        end else if (neg_q) begin
            // Magnitude is below 100 here, so the sign takes the first free digit.
            if (ten == 4'd0) begin
                bank_d = {OFF, MINUS, bcd_to_seg(one)};
            end else begin
                bank_d = {MINUS, bcd_to_seg(ten), bcd_to_seg(one)};
            end
        end else begin
            bank_d[20:14] = (hun == 4'd0) ? OFF : bcd_to_seg(hun);
            bank_d[13:7]  = (hun == 4'd0 && ten == 4'd0) ? OFF : bcd_to_seg(ten);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_tx_q  <= 1'b1;
            src_q      <= 1'b0;
            ovf_q      <= 1'b0;
            neg_q      <= 1'b0;
            rx_bank_q  <= BANK_RESET;
            tx_bank_q  <= BANK_RESET;
            done_q     <= 1'b0;
            done_src_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_rx || grant_tx) begin
                        src_q     <= grant_tx;
                        ovf_q     <= ovf_d;
                        neg_q     <= neg_d;
                        last_tx_q <= grant_tx;
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (last_shift) begin
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (src_q) begin
                        tx_bank_q <= bank_d;
                    end else begin
                        rx_bank_q <= bank_d;
                    end
                    done_q     <= 1'b1;
                    done_src_q <= src_q;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign {rx_d2, rx_d1, rx_d0} = rx_bank_q;
    assign {tx_d2, tx_d1, tx_d0} = tx_bank_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign done_src    = done_src_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seg_display_sched.sv
// -----------------------------------------------------------------------------
// tb_seg_display_sched
// Bench for seg_display_sched (W=8 main instance plus a W=12 instance for the
// overflow case). The reference keeps a countdown per accepted value and
// formats results with decimal arithmetic. Honours DISP_SIGNED_EN.
// -----------------------------------------------------------------------------
module tb_seg_display_sched;

    localparam int W = 8;

    localparam logic [6:0] S_OFF = 7'b1111111;
    localparam logic [6:0] S_MIN = 7'b0111111;
    localparam logic [6:0] S_0 = 7'b1000000;
    localparam logic [6:0] S_1 = 7'b1111001;
    localparam logic [6:0] S_2 = 7'b0100100;
    localparam logic [6:0] S_4 = 7'b0011001;
    localparam logic [6:0] S_5 = 7'b0010010;
    localparam logic [6:0] S_7 = 7'b1111000;

    logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    seg_display_sched_if #(.W(W))  bus();
    seg_display_sched_if #(.W(12)) bus12();

    logic [6:0] rx_d2, rx_d1, rx_d0, tx_d2, tx_d1, tx_d0;
    logic       busy, done, done_src;
    seg_pkg::seg_state_e dbg_state;

    logic [6:0] rx12_d2, rx12_d1, rx12_d0, tx12_d2, tx12_d1, tx12_d0;
    logic       busy12, done12, done_src12;
    seg_pkg::seg_state_e dbg_state12;

    seg_display_sched #(.W(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .rx_d2(rx_d2), .rx_d1(rx_d1), .rx_d0(rx_d0),
        .tx_d2(tx_d2), .tx_d1(tx_d1), .tx_d0(tx_d0),
        .busy(busy), .done(done), .done_src(done_src),
        .dbg_state_o(dbg_state)
    );

    seg_display_sched #(.W(12)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .bus(bus12),
        .rx_d2(rx12_d2), .rx_d1(rx12_d1), .rx_d0(rx12_d0),
        .tx_d2(tx12_d2), .tx_d1(tx12_d1), .tx_d0(tx12_d0),
        .busy(busy12), .done(done12), .done_src(done_src12),
        .dbg_state_o(dbg_state12)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [20:0] got, input logic [20:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s t=%0t got %h exp %h", name, $time, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    // Expected bank image for value v of width w, straight from the display rules.
    function automatic logic [20:0] fmt(input int v, input int w);
        int   mag;
        logic neg;
        neg = 1'b0;
        mag = v;
`ifdef DISP_SIGNED_EN
        if (v >= (1 << (w - 1))) begin
            neg = 1'b1;
            mag = (1 << w) - v;
        end
`endif
        if (neg) begin
            if (mag >= 100) return {S_MIN, S_MIN, S_MIN};
            if (mag >= 10)  return {S_MIN, seg_tab[mag / 10], seg_tab[mag % 10]};
            return {S_OFF, S_MIN, seg_tab[mag]};
        end
        if (mag > 999) return {S_MIN, S_MIN, S_MIN};
        return {(mag >= 100) ? seg_tab[mag / 100] : S_OFF,
                (mag >= 10)  ? seg_tab[(mag / 10) % 10] : S_OFF,
                seg_tab[mag % 10]};
    endfunction

    int          m_cnt;       // edges left until the bank write, 0 = idle
    logic        m_last_tx;
    int          m_val;
    logic        m_src;
    logic [20:0] exp_rx, exp_tx;
    logic        exp_done, exp_src;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt     <= 0;
            m_last_tx <= 1'b1;
            m_val     <= 0;
            m_src     <= 1'b0;
            exp_rx    <= {S_OFF, S_OFF, S_0};
            exp_tx    <= {S_OFF, S_OFF, S_0};
            exp_done  <= 1'b0;
            exp_src   <= 1'b0;
        end else begin
            exp_done <= 1'b0;
            if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    if (m_src) exp_tx <= fmt(m_val, W);
                    else       exp_rx <= fmt(m_val, W);
                    exp_done <= 1'b1;
                    exp_src  <= m_src;
                end
            end else if (bus.rx_valid && (!bus.tx_valid || m_last_tx)) begin
                m_cnt     <= W + 1;
                m_val     <= int'(bus.rx_data);
                m_src     <= 1'b0;
                m_last_tx <= 1'b0;
            end else if (bus.tx_valid) begin
                m_cnt     <= W + 1;
                m_val     <= int'(bus.tx_data);
                m_src     <= 1'b1;
                m_last_tx <= 1'b1;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            logic er, et;
            er = (m_cnt == 0) && bus.rx_valid && (!bus.tx_valid || m_last_tx);
            et = (m_cnt == 0) && bus.tx_valid && !er;
            check("rx_ready", 21'(bus.rx_ready), 21'(er));
            check("tx_ready", 21'(bus.tx_ready), 21'(et));
            check("busy", 21'(busy), 21'(m_cnt != 0));
            check("done", 21'(done), 21'(exp_done));
            check("done_src", 21'(done_src), 21'(exp_src));
            check("rx_bank", {rx_d2, rx_d1, rx_d0}, exp_rx);
            check("tx_bank", {tx_d2, tx_d1, tx_d0}, exp_tx);
        end
    end

    // ---------------- driver tasks ----------------
    // Call just after a rising edge; returns 1 time unit after the transfer edge.
    task automatic send(input bit is_tx, input int v);
        int t;
        t = 0;
        if (is_tx) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = W'(v);
        end else begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = W'(v);
        end
        @(negedge clk);
        while (!(is_tx ? bus.tx_ready : bus.rx_ready) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("ready_timeout", 21'(t), 21'(0));
        @(posedge clk);
        #1;
        if (is_tx) bus.tx_valid = 1'b0;
        else       bus.rx_valid = 1'b0;
    endtask

    // From just after a handshake edge k, move to the falling edge after k+W+1.
    task automatic wait_write();
        repeat (W + 1) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lit_rx(input string name, input int v, input logic [20:0] exp);
        send(1'b0, v);
        wait_write();
        check(name, {rx_d2, rx_d1, rx_d0}, exp);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    int rx_tab [0:7] = '{9, 10, 99, 100, 200, 255, 128, 251};
    int tx_tab [0:7] = '{1, 250, 64, 244, 0, 19, 127, 101};

    initial begin
        bus.rx_valid = 1'b0; bus.rx_data = '0;
        bus.tx_valid = 1'b0; bus.tx_data = '0;
        bus12.rx_valid = 1'b0; bus12.rx_data = '0;
        bus12.tx_valid = 1'b0; bus12.tx_data = '0;

        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        #1 rst_n = 1'b1;

        // Reset state.
        @(negedge clk);
        check("reset_rx_bank", {rx_d2, rx_d1, rx_d0}, {S_OFF, S_OFF, S_0});
        check("reset_tx_bank", {tx_d2, tx_d1, tx_d0}, {S_OFF, S_OFF, S_0});
        check("reset_busy", 21'(busy), 21'(0));

        // RX value 0: ready in the same cycle, bank at handshake edge + W + 1.
        @(posedge clk); #1;
        bus.rx_valid = 1'b1; bus.rx_data = 8'd0;
        @(negedge clk);
        check("first_rx_ready", 21'(bus.rx_ready), 21'(1));
        check("first_tx_ready", 21'(bus.tx_ready), 21'(0));
        send(1'b0, 0);
        wait_write();
        check("rx0_bank", {rx_d2, rx_d1, rx_d0}, {S_OFF, S_OFF, S_0});
        check("rx0_done", {20'd0, done}, 21'(1));
        check("rx0_src", {20'd0, done_src}, 21'(0));

        // TX value 255.
        @(posedge clk); #1;
        send(1'b1, 255);
        wait_write();
`ifdef DISP_SIGNED_EN
        check("tx255_bank", {tx_d2, tx_d1, tx_d0}, {S_OFF, S_MIN, S_1});
`else
        check("tx255_bank", {tx_d2, tx_d1, tx_d0}, {S_2, S_5, S_5});
`endif
        check("tx255_src", {20'd0, done_src}, 21'(1));
        check("tx255_rx_hold", {rx_d2, rx_d1, rx_d0}, {S_OFF, S_OFF, S_0});

        // Contention: both valid continuously, RX served first then alternating.
        @(posedge clk); #1;
        bus.rx_valid = 1'b1; bus.rx_data = 8'd7;
        bus.tx_valid = 1'b1; bus.tx_data = 8'd42;
        @(negedge clk);
        check("both_rx_first", {20'd0, bus.rx_ready}, 21'(1));
        check("both_tx_wait", {20'd0, bus.tx_ready}, 21'(0));
        repeat (4 * (W + 2)) @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.tx_valid = 1'b0;
        repeat (2 * (W + 2)) @(posedge clk);
        @(negedge clk);
        check("both_rx_bank", {rx_d2, rx_d1, rx_d0}, {S_OFF, S_OFF, S_7});
        check("both_tx_bank", {tx_d2, tx_d1, tx_d0}, {S_OFF, S_4, S_2});

        // Valid raised and dropped while busy: no transfer, no change.
        @(posedge clk); #1;
        send(1'b0, 33);
        bus.tx_valid = 1'b1; bus.tx_data = 8'd77;
        repeat (2) @(posedge clk);
        #1 bus.tx_valid = 1'b0;
        repeat (2 * (W + 2)) @(posedge clk);
        @(negedge clk);
        check("drop_tx_bank", {tx_d2, tx_d1, tx_d0}, {S_OFF, S_4, S_2});

        // Reset during SHIFT cycle 4 of rx_data=123.
        @(posedge clk); #1;
        send(1'b0, 123);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("abort_rx_bank", {rx_d2, rx_d1, rx_d0}, {S_OFF, S_OFF, S_0});
        check("abort_tx_bank", {tx_d2, tx_d1, tx_d0}, {S_OFF, S_OFF, S_0});
        check("abort_busy", {20'd0, busy}, 21'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (W + 4) @(posedge clk);
        @(negedge clk);
        check("abort_rx_after", {rx_d2, rx_d1, rx_d0}, {S_OFF, S_OFF, S_0});

        // Back-to-back directed values on both paths.
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            send(1'b0, rx_tab[i]);
            send(1'b1, tx_tab[i]);
        end
        repeat (2 * (W + 2)) @(posedge clk);
        #1;

        // Hand-computed displays.
`ifdef DISP_SIGNED_EN
        lit_rx("s_fb", 8'hFB, {S_OFF, S_MIN, S_5});
        lit_rx("s_f4", 8'hF4, {S_MIN, S_1, S_2});
        lit_rx("s_80", 8'h80, {S_MIN, S_MIN, S_MIN});
`else
        lit_rx("u_200", 200, {S_2, S_0, S_0});
        lit_rx("u_105", 105, {S_1, S_0, S_5});
        lit_rx("u_12", 12, {S_OFF, S_1, S_2});
`endif

        // W=12 instance: 1000 overflows three digits.
        begin
            int t;
            t = 0;
            bus12.rx_valid = 1'b1;
            bus12.rx_data  = 12'd1000;
            @(negedge clk);
            while (!bus12.rx_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            @(posedge clk); #1;
            bus12.rx_valid = 1'b0;
            t = 0;
            @(negedge clk);
            while (!done12 && t < 50) begin
                @(negedge clk);
                t++;
            end
            check("w12_done", {20'd0, done12}, 21'(1));
            check("w12_bank", {rx12_d2, rx12_d1, rx12_d0}, {S_MIN, S_MIN, S_MIN});
            check("w12_tx_hold", {tx12_d2, tx12_d1, tx12_d0}, {S_OFF, S_OFF, S_0});
        end

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got timeout exp finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
